// File: rtl/fetch_unit_8085.sv
// 8085 instruction fetch stage: reads byte-wide program memory at the PC and
// assembles 1/2/3-byte instructions, delivered over a valid/ready handshake.
module fetch_unit_8085 #(
    parameter int unsigned   AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [7:0]    HLT_OP   = 8'h76
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [7:0]    instr_opcode,
    output logic [7:0]    instr_op1,
    output logic [7:0]    instr_op2,
    output logic [1:0]    instr_len,
    output logic [AW-1:0] instr_pc,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          halted
);

    typedef enum logic [2:0] {F_OP, D_OP, D_B1, D_B2, VALID, HALT} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ipc_q, ipc_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [7:0]    op1_q, op1_d;
    logic [7:0]    op2_q, op2_d;
    logic [1:0]    len_q, len_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;
    logic          rd_c;
    logic [AW-1:0] addr_c;
    logic [1:0]    len_c;

    // Instruction length from the opcode byte alone.
    function automatic logic [1:0] op_len(input logic [7:0] o);
        logic three, two;
        three = (o[7:6] == 2'b00 && o[3:0] == 4'b0001) ||
                o == 8'h22 || o == 8'h2A || o == 8'h32 || o == 8'h3A ||
                o == 8'hC3 || o == 8'hCD ||
                (o[7:6] == 2'b11 && (o[2:0] == 3'b010 || o[2:0] == 3'b100));
        two   = (o[7:6] == 2'b00 && o[2:0] == 3'b110) ||
                (o[7:6] == 2'b11 && o[2:0] == 3'b110) ||
                o == 8'hD3 || o == 8'hDB;
        if (three)    return 2'd3;
        else if (two) return 2'd2;
        else          return 2'd1;
    endfunction

    assign len_c = op_len(mem_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= F_OP;
            pc_q     <= RESET_PC;
            ipc_q    <= '0;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            len_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ipc_q    <= ipc_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            len_q    <= len_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ipc_d    = ipc_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        len_d    = len_q;
        valid_d  = 1'b0;
        halted_d = 1'b0;
        rd_c     = 1'b0;
        addr_c   = pc_q;

        case (state_q)
            F_OP: begin
                rd_c    = 1'b1;
                state_d = D_OP;
            end
            D_OP: begin
                opcode_d = mem_data;
                op1_d    = '0;
                op2_d    = '0;
                len_d    = len_c;
                ipc_d    = pc_q;
                pc_d     = pc_q + AW'(1);
                if (len_c == 2'd1) begin
                    state_d = VALID;
                    valid_d = 1'b1;
                end else begin
                    rd_c    = 1'b1;
                    addr_c  = pc_q + AW'(1);
                    state_d = D_B1;
                end
            end
            D_B1: begin
                op1_d = mem_data;
                pc_d  = pc_q + AW'(1);
                if (len_q == 2'd2) begin
                    state_d = VALID;
                    valid_d = 1'b1;
                end else begin
                    rd_c    = 1'b1;
                    addr_c  = pc_q + AW'(1);
                    state_d = D_B2;
                end
            end
            D_B2: begin
                op2_d   = mem_data;
                pc_d    = pc_q + AW'(1);
                state_d = VALID;
                valid_d = 1'b1;
            end
            VALID: begin
                valid_d = 1'b1;
                if (instr_ready) begin
                    valid_d  = 1'b0;
                    halted_d = (opcode_q == HLT_OP);
                    state_d  = (opcode_q == HLT_OP) ? HALT : F_OP;
                end
            end
            HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = F_OP;
            end
        endcase

        // Redirect overrides everything; in-flight read data is simply never latched.
        if (redirect) begin
            pc_d     = redirect_pc;
            state_d  = F_OP;
            valid_d  = 1'b0;
            halted_d = 1'b0;
        end
    end

    assign mem_rd       = rd_c & ~reset;
    assign mem_addr     = addr_c;
    assign instr_valid  = valid_q;
    assign instr_opcode = opcode_q;
    assign instr_op1    = op1_q;
    assign instr_op2    = op2_q;
    assign instr_len    = len_q;
    assign instr_pc     = ipc_q;
    assign halted       = halted_q;

endmodule
